// File: rtl/sdram_pkg.sv
// sdram_pkg: command codes, FSM state encoding and default timing for the
// SDRAM write-burst engine.
package sdram_pkg;

    // {CS,RAS,CAS,WE}
    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ACT    = 4'd1,
        ST_TRCD   = 4'd2,
        ST_WR_CMD = 4'd3,
        ST_DATA   = 4'd4,
        ST_TWR    = 4'd5,
        ST_PRE    = 4'd6,
        ST_TRP    = 4'd7,
        ST_END    = 4'd8
    } state_e;

    localparam int DEF_TRCD = 2;
    localparam int DEF_TWR  = 2;
    localparam int DEF_TRP  = 2;

endpackage

// File: rtl/sdram_wr_burst_seg_calc.sv
// sdram_seg_calc: combinational segment length and next {bank,row}.
// With SDRAM_WR_PAGE_SPLIT_EN defined a segment stops at the end of the
// open page; otherwise the whole remaining length is one segment and the
// SDRAM's native full-page column wrap applies.
module sdram_seg_calc import sdram_pkg::*; #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int LEN_W  = 10
) (
    input  logic [COL_W-1:0]        col_i,
    input  logic [LEN_W-1:0]        rem_i,
    input  logic [BANK_W+ROW_W-1:0] br_i,
    output logic [LEN_W-1:0]        seg_len_o,
    output logic [BANK_W+ROW_W-1:0] br_next_o
);

`ifdef SDRAM_WR_PAGE_SPLIT_EN
    // Words left before the page boundary; one bit wider so a full page fits.
    logic [LEN_W:0] room;
    assign room      = (LEN_W+1)'(2**COL_W) - (LEN_W+1)'(col_i);
    assign seg_len_o = ({1'b0, rem_i} < room) ? rem_i : room[LEN_W-1:0];
`else
    logic unused_col;
    assign unused_col = ^col_i;
    assign seg_len_o  = rem_i;
`endif

    // Row overflow carries into bank; all-ones wraps to zero.
    assign br_next_o = br_i + (BANK_W+ROW_W)'(1);

endmodule

// File: rtl/sdram_wr_burst.sv
// sdram_wr_burst: SDRAM write-burst engine. Opens a row, issues WRITE,
// streams wr_data on wr_ack, terminates with BURST_STOP, then precharges.
// Optional macro SDRAM_WR_PAGE_SPLIT_EN splits page-crossing bursts into
// per-row segments (see sdram_seg_calc).
module sdram_wr_burst import sdram_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int LEN_W  = 10,
    parameter int TRCD   = DEF_TRCD,
    parameter int TWR    = DEF_TWR,
    parameter int TRP    = DEF_TRP
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic                          init_end,
    input  logic                          wr_en,
    input  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]              wr_burst_len,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ack,
    output logic                          wr_end,
    output logic [3:0]                    wr_sdram_cmd,
    output logic [BANK_W-1:0]             wr_sdram_bank,
    output logic [ROW_W-1:0]              wr_sdram_addr,
    output logic                          wr_sdram_en,
    output logic [DATA_W-1:0]             wr_sdram_data
);

    localparam int BR_W = BANK_W + ROW_W;

    state_e              state_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    rem_q;
    logic [BR_W-1:0]     br_q;
    logic [COL_W-1:0]    col_q;
    logic [3:0]          cmd_q;
    logic [BANK_W-1:0]   ba_q;
    logic [ROW_W-1:0]    addr_q;
    logic                en_q;

    logic [LEN_W-1:0]    seg_len;
    logic [BR_W-1:0]     br_next;
    logic [LEN_W:0]      cnt_p1;
    logic                last_data;

    sdram_seg_calc #(
        .BANK_W (BANK_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .LEN_W  (LEN_W)
    ) u_seg_calc (
        .col_i     (col_q),
        .rem_i     (rem_q),
        .br_i      (br_q),
        .seg_len_o (seg_len),
        .br_next_o (br_next)
    );

    assign cnt_p1    = {1'b0, cnt_q} + (LEN_W+1)'(1);
    assign last_data = (cnt_q == seg_len - LEN_W'(1));

    // One ack in WR_CMD plus seg_len-1 in DATA: the word for each ack is
    // on wr_data the following cycle, aligned with wr_sdram_en.
    assign wr_ack = (state_q == ST_WR_CMD) ||
                    ((state_q == ST_DATA) && (cnt_p1 < {1'b0, seg_len}));
    assign wr_end = (state_q == ST_END);

    assign wr_sdram_cmd  = cmd_q;
    assign wr_sdram_bank = ba_q;
    assign wr_sdram_addr = addr_q;
    assign wr_sdram_en   = en_q;
    assign wr_sdram_data = en_q ? wr_data : '0;

    // Sequencer; command bus is registered from the current state.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            br_q    <= '0;
            col_q   <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '1;
            addr_q  <= '1;
            en_q    <= 1'b0;
        end else begin
            en_q   <= wr_ack;
            cmd_q  <= CMD_NOP;
            ba_q   <= '1;
            addr_q <= '1;
            case (state_q)
                ST_IDLE: begin
                    if (init_end && wr_en && (wr_burst_len != '0)) begin
                        br_q    <= wr_addr[BR_W+COL_W-1:COL_W];
                        col_q   <= wr_addr[COL_W-1:0];
                        rem_q   <= wr_burst_len;
                        state_q <= ST_ACT;
                    end
                end
                ST_ACT: begin
                    cmd_q   <= CMD_ACTIVE;
                    ba_q    <= br_q[BR_W-1:ROW_W];
                    addr_q  <= br_q[ROW_W-1:0];
                    cnt_q   <= '0;
                    state_q <= ST_TRCD;
                end
                ST_TRCD: begin
                    if (cnt_q == LEN_W'(TRCD-1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_WR_CMD;
                    end else begin
                        cnt_q <= cnt_p1[LEN_W-1:0];
                    end
                end
                ST_WR_CMD: begin
                    cmd_q   <= CMD_WRITE;
                    ba_q    <= br_q[BR_W-1:ROW_W];
                    addr_q  <= ROW_W'(col_q);
                    cnt_q   <= '0;
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (last_data) begin
                        cmd_q   <= CMD_BURST_STOP;
                        rem_q   <= rem_q - seg_len;
                        cnt_q   <= '0;
                        state_q <= ST_TWR;
                    end else begin
                        cnt_q <= cnt_p1[LEN_W-1:0];
                    end
                end
                ST_TWR: begin
                    if (cnt_q == LEN_W'(TWR-1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_PRE;
                    end else begin
                        cnt_q <= cnt_p1[LEN_W-1:0];
                    end
                end
                ST_PRE: begin
                    cmd_q      <= CMD_PRECHARGE;
                    ba_q       <= br_q[BR_W-1:ROW_W];
                    addr_q     <= '0;
                    addr_q[10] <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= ST_TRP;
                end
                ST_TRP: begin
                    if (cnt_q == LEN_W'(TRP-1)) begin
                        cnt_q <= '0;
                        if (rem_q != '0) begin
                            br_q    <= br_next;
                            col_q   <= '0;
                            state_q <= ST_ACT;
                        end else begin
                            state_q <= ST_END;
                        end
                    end else begin
                        cnt_q <= cnt_p1[LEN_W-1:0];
                    end
                end
                ST_END:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// Bench for sdram_wr_burst: directed and random requests checked cycle by
// cycle against an expected command/data stream built from the timing rules.
module tb_sdram_wr_burst;

    localparam int DW = 16, BW = 2, RW = 13, CW = 9, LW = 10;
    localparam int PAGE = 1 << CW;
    localparam int T_RCD = 2, T_WR = 2, T_RP = 2;
    localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_ACT = 4'b0011,
                           C_WR  = 4'b0100, C_BST = 4'b0110;

    logic               wr_clk = 1'b0;
    logic               wr_rst_n = 1'b0;
    logic               init_end = 1'b0;
    logic               wr_en = 1'b0;
    logic [BW+RW+CW-1:0] wr_addr = '0;
    logic [LW-1:0]      wr_burst_len = '0;
    logic [DW-1:0]      wr_data = '0;
    logic               wr_ack, wr_end, wr_sdram_en;
    logic [3:0]         wr_sdram_cmd;
    logic [BW-1:0]      wr_sdram_bank;
    logic [RW-1:0]      wr_sdram_addr;
    logic [DW-1:0]      wr_sdram_data;

    int n_cmp = 0;
    int n_err = 0;

    sdram_wr_burst #(
        .DATA_W(DW), .BANK_W(BW), .ROW_W(RW), .COL_W(CW), .LEN_W(LW),
        .TRCD(T_RCD), .TWR(T_WR), .TRP(T_RP)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_rst_n      (wr_rst_n),
        .init_end      (init_end),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_burst_len  (wr_burst_len),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .wr_end        (wr_end),
        .wr_sdram_cmd  (wr_sdram_cmd),
        .wr_sdram_bank (wr_sdram_bank),
        .wr_sdram_addr (wr_sdram_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data)
    );

    always #5 wr_clk = ~wr_clk;

    // amode: 0 = don't care, 1 = full address, 2 = A10 only
    typedef struct {
        logic [3:0]    cmd;
        bit            bchk;
        logic [BW-1:0] ba;
        int            amode;
        logic [RW-1:0] addr;
        bit            en;
        int            widx;
        bit            endp;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] cmd, input bit bchk, input logic [BW-1:0] ba,
                                input int amode, input logic [RW-1:0] addr, input bit en, input int widx);
        exp_t e;
        e.cmd = cmd; e.bchk = bchk; e.ba = ba; e.amode = amode; e.addr = addr;
        e.en = en; e.widx = widx; e.endp = 1'b0;
        return e;
    endfunction

    // Reference: the command stream a request should produce, one entry per
    // cycle starting with the cycle the ACTIVE command appears.
    task automatic build(input logic [BW+RW-1:0] br, input int col, input int len);
        int rem, c, seg, w;
        logic [BW+RW-1:0] b;
        exp_t nop;
        nop = mk(C_NOP, 1'b1, '1, 1, '1, 1'b0, 0);
        exp_q.delete();
        rem = len; c = col; b = br; w = 0;
        while (rem > 0) begin
`ifdef SDRAM_WR_PAGE_SPLIT_EN
            seg = (rem < PAGE - c) ? rem : PAGE - c;
`else
            seg = rem;
`endif
            exp_q.push_back(mk(C_ACT, 1'b1, b[BW+RW-1:RW], 1, b[RW-1:0], 1'b0, 0));
            for (int i = 0; i < T_RCD; i++) exp_q.push_back(nop);
            for (int j = 0; j < seg; j++) begin
                if (j == 0) exp_q.push_back(mk(C_WR, 1'b1, b[BW+RW-1:RW], 1, RW'(c), 1'b1, w));
                else        exp_q.push_back(mk(C_NOP, 1'b1, '1, 1, '1, 1'b1, w));
                w++;
            end
            exp_q.push_back(mk(C_BST, 1'b0, '0, 0, '0, 1'b0, 0));
            for (int i = 0; i < T_WR; i++) exp_q.push_back(nop);
            exp_q.push_back(mk(C_PRE, 1'b1, b[BW+RW-1:RW], 2, '0, 1'b0, 0));
            for (int i = 0; i < T_RP; i++) exp_q.push_back(nop);
            rem -= seg;
            b = b + (BW+RW)'(1);
            c = 0;
        end
        exp_q[exp_q.size()-1].endp = 1'b1;
        exp_q.push_back(nop);
    endtask

    // Issue one request and follow it to completion. Entered between a
    // negedge and the next posedge; returns in the same phase.
    task automatic run_req(input logic [BW+RW-1:0] br, input int col, input int len, input string tag);
        int acks = 0, drv = 0;
        bit ack_prev;
        logic [DW-1:0] words[$];
        logic [DW-1:0] expd;
        build(br, col, len);
        for (int i = 0; i < len; i++) words.push_back(DW'($urandom));
        init_end = 1'b1; wr_en = 1'b1;
        wr_addr = {br, CW'(col)}; wr_burst_len = LW'(len);
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        @(negedge wr_clk);
        chk({tag, "/first_cmd"}, 32'(wr_sdram_cmd), 32'(C_NOP));
        ack_prev = wr_ack; if (wr_ack) acks++;
        foreach (exp_q[i]) begin
            @(posedge wr_clk); #1;
            // Latched request must be immune to later input changes.
            wr_addr = (BW+RW+CW)'($urandom);
            wr_burst_len = LW'($urandom);
            if (ack_prev && drv < len) begin wr_data = words[drv]; drv++; end
            else wr_data = DW'($urandom);
            @(negedge wr_clk);
            chk({tag, "/cmd"}, 32'(wr_sdram_cmd), 32'(exp_q[i].cmd));
            if (exp_q[i].bchk) chk({tag, "/bank"}, 32'(wr_sdram_bank), 32'(exp_q[i].ba));
            if (exp_q[i].amode == 1) chk({tag, "/addr"}, 32'(wr_sdram_addr), 32'(exp_q[i].addr));
            if (exp_q[i].amode == 2) chk({tag, "/a10"}, 32'(wr_sdram_addr[10]), 32'd1);
            chk({tag, "/en"}, 32'(wr_sdram_en), 32'(exp_q[i].en));
            expd = exp_q[i].en ? words[exp_q[i].widx] : '0;
            chk({tag, "/data"}, 32'(wr_sdram_data), 32'(expd));
            chk({tag, "/end"}, 32'(wr_end), 32'(exp_q[i].endp));
            ack_prev = wr_ack; if (wr_ack) acks++;
        end
        repeat (3) begin
            @(negedge wr_clk);
            chk({tag, "/idle_cmd"}, 32'(wr_sdram_cmd), 32'(C_NOP));
            chk({tag, "/idle_end"}, 32'(wr_end), 32'd0);
            if (wr_ack) acks++;
        end
        chk({tag, "/acks"}, 32'(acks), 32'(len));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/cmd"},  32'(wr_sdram_cmd),  32'(C_NOP));
        chk({tag, "/bank"}, 32'(wr_sdram_bank), 32'(2**BW - 1));
        chk({tag, "/addr"}, 32'(wr_sdram_addr), 32'(2**RW - 1));
        chk({tag, "/en"},   32'(wr_sdram_en),   32'd0);
        chk({tag, "/ack"},  32'(wr_ack),        32'd0);
        chk({tag, "/end"},  32'(wr_end),        32'd0);
        chk({tag, "/data"}, 32'(wr_sdram_data), 32'd0);
    endtask

    // Request gating: nothing may leave IDLE.
    task automatic gate(input string tag, input bit ie, input int len);
        init_end = ie; wr_en = 1'b1;
        wr_addr = (BW+RW+CW)'($urandom); wr_burst_len = LW'(len);
        repeat (8) begin
            @(negedge wr_clk);
            chk({tag, "/cmd"}, 32'(wr_sdram_cmd), 32'(C_NOP));
            chk({tag, "/ack"}, 32'(wr_ack), 32'd0);
            chk({tag, "/end"}, 32'(wr_end), 32'd0);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        logic [BW+RW-1:0] rbr;
        int rcol, rlen;

        wr_data = 16'h1234;
        repeat (2) @(negedge wr_clk);
        chk_reset_vals("reset");
        wr_rst_n = 1'b1;
        @(negedge wr_clk);

        gate("no_init", 1'b0, 4);
        gate("len0", 1'b1, 0);

        run_req({2'd0, 13'd5},    0,   4,   "basic");
        run_req({2'd1, 13'd100},  510, 4,   "col510");
        run_req({2'd0, 13'd8191}, 511, 2,   "wrap");
        run_req({2'd2, 13'd7},    0,   512, "fullpage");
        run_req({2'd3, 13'd8191}, 300, 700, "long");
        run_req({2'd1, 13'd42},   17,  1,   "len1");

        // Reset during DATA aborts at once; no PRECHARGE follows.
        init_end = 1'b1; wr_en = 1'b1;
        wr_addr = {2'd1, 13'd77, 9'd3}; wr_burst_len = 10'd20;
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge wr_clk);
            if (wr_sdram_en) found = 1'b1;
        end
        chk("midrst/reach_data", 32'(found), 32'd1);
        #1 wr_data = 16'hA5A5; wr_rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (2) begin
            @(negedge wr_clk);
            chk("midrst/hold_cmd", 32'(wr_sdram_cmd), 32'(C_NOP));
        end
        wr_rst_n = 1'b1;
        repeat (2) begin
            @(negedge wr_clk);
            chk("post_rst/cmd", 32'(wr_sdram_cmd), 32'(C_NOP));
        end
        run_req({2'd0, 13'd9}, 0, 4, "post_rst");

        for (int k = 0; k < 20; k++) begin
            rbr  = (BW+RW)'($urandom);
            rcol = ($urandom_range(0, 1) == 1) ? int'($urandom_range(500, 511)) : int'($urandom_range(0, 511));
            rlen = ($urandom_range(0, 5) == 0) ? int'($urandom_range(500, 700)) : int'($urandom_range(1, 20));
            run_req(rbr, rcol, rlen, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_wr_burst.md
SDRAM_WR_BURST -- requirements
Module: sdram_wr_burst

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 16, data width.
- BANK_W, 2, bank bits.
- ROW_W, 13, row bits.
- COL_W, 9, column bits.
- LEN_W, 10, burst-length bits.
- TRCD, 2, ACTIVE-to-WRITE cycles.
- TWR, 2, last-data-to-PRECHARGE cycles.
- TRP, 2, PRECHARGE-to-ACTIVE cycles.

REQ-002 Ports (name, direction, width, meaning):
- wr_clk, in, 1, clock.
- wr_rst_n, in, 1, reset: asynchronous, active-low.
- init_end, in, 1, SDRAM init complete.
- wr_en, in, 1, write request.
- wr_addr, in, BANK_W+ROW_W+COL_W, start address {bank,row,col}.
- wr_burst_len, in, LEN_W, word count.
- wr_data, in, DATA_W, write data.
- wr_ack, out, 1, data request strobe.
- wr_end, out, 1, request-complete pulse.
- wr_sdram_cmd, out, 4, {CS,RAS,CAS,WE}.
- wr_sdram_bank, out, BANK_W, bank address.
- wr_sdram_addr, out, ROW_W, SDRAM address bus.
- wr_sdram_en, out, 1, DQ drive enable.
- wr_sdram_data, out, DATA_W, DQ data.

Function
REQ-003 Command codes: NOP 0111, PRECHARGE 0010, ACTIVE 0011, WRITE 0100, BURST_STOP 0110.
REQ-004 States: IDLE, ACT, TRCD, WR_CMD, DATA, TWR, PRE, TRP, END.
REQ-005 IDLE->ACT when init_end & wr_en & wr_burst_len!=0. Address and length are latched on this transition; later input changes are ignored until IDLE. A request with length 0 is ignored.
REQ-006 ACT: one cycle. TRCD: TRCD cycles. WR_CMD: one cycle. DATA: seg_len cycles. TWR: TWR cycles. PRE: one cycle. TRP: TRP cycles. END: one cycle, then IDLE.
REQ-007 Command outputs are registered and issued one cycle after the state that selects them:
- ACT: ACTIVE, latched bank, current row.
- WR_CMD: WRITE, bank, {zero-padded current col}, A10=0.
- Last DATA cycle: BURST_STOP.
- PRE: PRECHARGE, bank, A10=1.
- All other cycles: NOP, bank all-ones, addr all-ones.
REQ-008 wr_ack is combinational: high in WR_CMD and in DATA while cnt <= seg_len-2, giving exactly seg_len acks per segment.
REQ-009 wr_sdram_en is wr_ack registered. wr_sdram_data = wr_sdram_en ? wr_data : 0. The first word coincides with the WRITE command.
REQ-010 seg_len = min(remaining, 2^COL_W - col). remaining is decremented by seg_len at the end of DATA.
REQ-011 After TRP: if remaining>0, go to ACT with {bank,row}+1 and col=0. Otherwise go to END.
REQ-012 {bank,row} increments as one BANK_W+ROW_W-bit value: row overflow carries into bank, and all-ones wraps to zero.
REQ-013 wr_end is high exactly one cycle, while in END.
REQ-014 wr_burst_len = 2^COL_W at col 0 produces one full-page segment.

Reset
REQ-015 Reset values: wr_sdram_cmd=NOP; wr_sdram_bank and wr_sdram_addr all-ones; wr_sdram_en=0; wr_ack=0; wr_end=0; state IDLE; all counters 0.
REQ-016 Reset asserted mid-operation aborts immediately, with no PRECHARGE issued. After release the block waits in IDLE for a new request.

Configuration
REQ-017 Macro SDRAM_WR_PAGE_SPLIT_EN defined: page-crossing bursts split per REQ-010/011.
REQ-018 Macro undefined:
- seg_len = remaining.
- The column wraps within the open row; the SDRAM's native full-page behaviour applies.
- Exactly one segment per request.
- Lengths above 2^COL_W overwrite earlier columns of the same row.

Structure
REQ-019 Package sdram_pkg holds the command codes, the state encoding (4-bit) and the default timing constants.
REQ-020 One sub-module, sdram_seg_calc, computes seg_len and the next {bank,row}; it is combinational.

Verification
REQ-021 Basic burst: addr {0,5,0}, len 4.
- Expect ACTIVE row 5, 2 NOPs, WRITE col 0.
- Expect 4 wr_sdram_en cycles with data D0..D3, then BURST_STOP, 2 NOPs, PRECHARGE, 2 NOPs.
- Expect wr_end one cycle.
REQ-022 Split enabled: col 510, len 4.
- Expect WRITE col 510 with 2 words, BURST_STOP, PRECHARGE, then ACTIVE row+1, WRITE col 0 with 2 words.
- Expect total acks 4 and a single wr_end.
REQ-023 Split disabled: same stimulus as REQ-022.
- Expect one WRITE col 510, 4 words, one BURST_STOP, row unchanged.
REQ-024 Request gating and latching:
- wr_en=1 with init_end=0: expect commands stay NOP.
- len=0: expect no action.
- Change wr_addr/wr_burst_len mid-burst: expect no effect.
REQ-025 Row/bank wrap: split enabled, bank 0, row 8191, col 511, len 2.
- Expect second ACTIVE to bank 1, row 0.
REQ-026 Reset mid-burst: assert wr_rst_n low during DATA.
- Expect outputs at reset values within the same cycle.
- After release, a new len 4 request completes normally.
